video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Programmable raster timing generator that produces the hsync/vsync/hblank/vblank set consumed by the video overlay/scandoubler stage.
- Also gives the game core pixel coordinates, a data-enable, and line/frame strobes.
- Advances one pixel per clock-enable, so it runs on the system clk at any pixel rate.
- Replaces ad-hoc sync counters inside game cores with one reusable, verified source.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, active level of hsync (0 = active-low)
- VS_POL, 0, active level of vsync (0 = active-low)
- Derived localparams: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; HCW = $clog2(H_TOTAL); VCW = $clog2(V_TOTAL)

Ports:
- clk, input, 1, system clock
- reset, input, 1, synchronous, active-high
- ce_pix, input, 1, pixel clock enable; counters advance only when high
- hcount, output, HCW, current pixel column, 0..H_TOTAL-1
- vcount, output, VCW, current line, 0..V_TOTAL-1
- hblank, output, 1, high when hcount >= H_ACTIVE
- vblank, output, 1, high when vcount >= V_ACTIVE
- hsync, output, 1, HS_POL while H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL
- vsync, output, 1, VS_POL while V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL
- de, output, 1, ~hblank & ~vblank
- line_start, output, 1, one-clk pulse when hcount enters 0
- frame_start, output, 1, one-clk pulse when (hcount,vcount) enters (0,0)
- frame_cnt, output, 8, frames completed, modulo 256

Behaviour:
- Every output is a register, and all outputs are mutually aligned. The decode for position (h,v) is registered in the same clk edge that loads h,v, so hcount/vcount always match the flags presented alongside them.
- On a clk edge with ce_pix=1 and reset=0:
  - h <= (h == H_TOTAL-1) ? 0 : h+1.
  - On the h wrap only: v <= (v == V_TOTAL-1) ? 0 : v+1.
- vsync and vblank change only on a line boundary, coincident with hcount=0.
- Strobes:
  - line_start = 1 for exactly one clk on the edge that wraps h to 0; otherwise 0.
  - frame_start = 1 for exactly one clk on the edge that wraps both h and v to 0.
  - frame_cnt increments on that same edge, 255 -> 0.
- ce_pix=0: all counters and level outputs hold; line_start and frame_start are 0.
- Latency: a ce_pix at edge N shows the new position and flags after edge N; no further pipeline delay.
- Reset (synchronous, wins over ce_pix):
  - hcount=0, vcount=0, frame_cnt=0.
  - hblank=0, vblank=0, de=1 (decode of (0,0)).
  - hsync=~HS_POL, vsync=~VS_POL.
  - line_start=0, frame_start=0.
- Reset mid-frame: on the next edge, jump to the state above. No strobe is emitted for this jump. The first line_start after release comes H_TOTAL ce_pix pulses later.
- Arithmetic: unsigned compares against localparam boundaries. Compare constants are widened to the counter width. No counter value >= total is ever reachable.
- Parameter sanity: elaboration error if any porch or sync parameter is 0, or if H_ACTIVE or V_ACTIVE is 0.

Decomposition:
- Package video_timing_pkg holds:
  - preset localparams for 640x480@60 (defaults above) and 320x240 15 kHz;
  - a typedef struct for the timing tuple (active, fp, sync, bp).
- One sub-module, video_timing_axis, instantiated twice (horizontal step=ce_pix; vertical step=ce_pix & h_wrap). Parameters: ACTIVE/FP/SYNC/BP/POL. Outputs: count, blank, sync, wrap.
- Top-level logic: frame_cnt, the strobes, and de.

Test Plan:
- Defaults, ce_pix=1 constant: hsync low exactly 96 clks, first falling edge at hcount=656. line_start period 800 clks. hblank high 160 clks per line.
- Defaults, ce_pix=1: frame_start period 420000 clks. vsync low 1600 clks, asserting at vcount=490, hcount=0. de high 307200 clks per frame.
- ce_pix toggling every other clk: all periods double (line_start every 1600 clks). Outputs stable on ce_pix=0 cycles, and strobes stay exactly one clk wide.
- Reset asserted at hcount=300, vcount=200 with ce_pix=1: next edge shows (0,0), de=1, no line_start or frame_start. After release, first line_start comes 800 ce_pix later.
- HS_POL=1, VS_POL=1: sync pulses inverted, identical positions and widths. Reset value hsync=0, vsync=0.
- Run 257 frames: frame_cnt reads 0 after frame 256 and 1 after frame 257.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared raster timing types, presets and helpers for video_timing_gen.
// A timing tuple describes one axis: active, front porch, sync, back porch.
package video_timing_pkg;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } timing_t;

  localparam timing_t VGA640_H = '{active: 32'sd640, fp: 32'sd16, sync: 32'sd96, bp: 32'sd48};
  localparam timing_t VGA640_V = '{active: 32'sd480, fp: 32'sd10, sync: 32'sd2,  bp: 32'sd33};
  localparam timing_t LOW15K_H = '{active: 32'sd320, fp: 32'sd20, sync: 32'sd30, bp: 32'sd40};
  localparam timing_t LOW15K_V = '{active: 32'sd240, fp: 32'sd3,  sync: 32'sd3,  bp: 32'sd16};

  function automatic int timing_total(input timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  function automatic bit timing_valid(input timing_t t);
    return (t.active > 32'sd0) && (t.fp > 32'sd0) && (t.sync > 32'sd0) && (t.bp > 32'sd0);
  endfunction

endpackage

// File: rtl/video_timing_axis.sv
// One raster axis: wrapping position counter with registered blank/sync decode.
// Flags are decoded from the next count so they load on the same edge as the count.
module video_timing_axis
  import video_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter bit POL    = 1'b0,
  parameter int CW     = $clog2(ACTIVE + FP + SYNC + BP)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step,
  output logic [CW-1:0] count,
  output logic          blank,
  output logic          sync,
  output logic          wrap,
  output logic          blank_next
);

  localparam timing_t T     = '{active: ACTIVE, fp: FP, sync: SYNC, bp: BP};
  localparam int      TOTAL = timing_total(T);

  localparam logic [CW-1:0] LAST        = CW'(TOTAL - 1);
  localparam logic [CW-1:0] BLANK_START = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_START  = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END    = CW'(ACTIVE + FP + SYNC);

  if (!timing_valid(T)) begin : g_param_check
    $error("video_timing_axis: active, porch and sync widths must all be non-zero");
  end

  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic          blank_r;
  logic          sync_r;
  logic          blank_next_s;
  logic          sync_next_s;
  logic          wrap_s;

  assign wrap_s = (count_r == LAST);

  // Next position and its decode
  always_comb begin
    count_next_s = count_r;
    if (step) begin
      if (wrap_s) begin
        count_next_s = '0;
      end else begin
        count_next_s = count_r + CW'(1'b1);
      end
    end else begin
      count_next_s = count_r;
    end
    blank_next_s = (count_next_s >= BLANK_START);
    if ((count_next_s >= SYNC_START) && (count_next_s < SYNC_END)) begin
      sync_next_s = POL;
    end else begin
      sync_next_s = ~POL;
    end
  end

  // Count and flags load together so they always describe the same position
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
      blank_r <= 1'b0;
      sync_r  <= ~POL;
    end else begin
      count_r <= count_next_s;
      blank_r <= blank_next_s;
      sync_r  <= sync_next_s;
    end
  end

  assign count      = count_r;
  assign blank      = blank_r;
  assign sync       = sync_r;
  assign wrap       = wrap_s;
  assign blank_next = blank_next_s;

endmodule

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: pixel/line counters, sync/blank flags,
// data-enable, line/frame strobes and a frame counter, all registered and aligned.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HCW     = $clog2(H_TOTAL),
  localparam int VCW     = $clog2(V_TOTAL)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ce_pix,
  output logic [HCW-1:0] hcount,
  output logic [VCW-1:0] vcount,
  output logic           hblank,
  output logic           vblank,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic           line_start,
  output logic           frame_start,
  output logic [7:0]     frame_cnt
);

  logic h_wrap_s;
  logic v_wrap_s;
  logic v_step_s;
  logic h_blank_next_s;
  logic v_blank_next_s;
  logic line_start_r;
  logic frame_start_r;
  logic de_r;
  logic [7:0] frame_cnt_r;

  assign v_step_s = ce_pix & h_wrap_s;

  video_timing_axis #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .CW(HCW)
  ) u_h_axis (
    .clk        (clk),
    .reset      (reset),
    .step       (ce_pix),
    .count      (hcount),
    .blank      (hblank),
    .sync       (hsync),
    .wrap       (h_wrap_s),
    .blank_next (h_blank_next_s)
  );

  video_timing_axis #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .CW(VCW)
  ) u_v_axis (
    .clk        (clk),
    .reset      (reset),
    .step       (v_step_s),
    .count      (vcount),
    .blank      (vblank),
    .sync       (vsync),
    .wrap       (v_wrap_s),
    .blank_next (v_blank_next_s)
  );

  // Strobes fire on the wrapping edge; a reset jump to (0,0) emits none
  always_ff @(posedge clk) begin
    if (reset) begin
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      frame_cnt_r   <= 8'd0;
      de_r          <= 1'b1;
    end else begin
      line_start_r  <= ce_pix & h_wrap_s;
      frame_start_r <= ce_pix & h_wrap_s & v_wrap_s;
      if (ce_pix & h_wrap_s & v_wrap_s) begin
        frame_cnt_r <= frame_cnt_r + 8'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
      de_r <= ~h_blank_next_s & ~v_blank_next_s;
    end
  end

  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;
  assign frame_cnt   = frame_cnt_r;
  assign de          = de_r;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: a small raster (16x8, both polarities)
// for full-frame behaviour and a default 640x480 instance for line timing.
module tb_video_timing_gen;

  localparam int HT = 16;
  localparam int VT = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ce_pix = 1'b0;

  logic [3:0] s_hcount, i_hcount;
  logic [2:0] s_vcount, i_vcount;
  logic s_hblank, s_vblank, s_hsync, s_vsync, s_de, s_line_start, s_frame_start;
  logic i_hblank, i_vblank, i_hsync, i_vsync, i_de, i_line_start, i_frame_start;
  logic [7:0] s_frame_cnt, i_frame_cnt, g_frame_cnt;
  logic [9:0] g_hcount, g_vcount;
  logic g_hblank, g_vblank, g_hsync, g_vsync, g_de, g_line_start, g_frame_start;

  int checks = 0;
  int failures = 0;
  int h_m = 0;
  int v_m = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .hcount(s_hcount), .vcount(s_vcount),
    .hblank(s_hblank), .vblank(s_vblank), .hsync(s_hsync), .vsync(s_vsync), .de(s_de),
    .line_start(s_line_start), .frame_start(s_frame_start), .frame_cnt(s_frame_cnt)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_inv (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .hcount(i_hcount), .vcount(i_vcount),
    .hblank(i_hblank), .vblank(i_vblank), .hsync(i_hsync), .vsync(i_vsync), .de(i_de),
    .line_start(i_line_start), .frame_start(i_frame_start), .frame_cnt(i_frame_cnt)
  );

  video_timing_gen dut_vga (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .hcount(g_hcount), .vcount(g_vcount),
    .hblank(g_hblank), .vblank(g_vblank), .hsync(g_hsync), .vsync(g_vsync), .de(g_de),
    .line_start(g_line_start), .frame_start(g_frame_start), .frame_cnt(g_frame_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ce_pix = 1'b1;
    tick();
    reset = 1'b0;
    h_m = 0;
    v_m = 0;
  endtask

  // Reference raster position for the 16x8 instances
  task automatic model_step(input bit ce, output bit lw, output bit fw);
    lw = 1'b0;
    fw = 1'b0;
    if (ce) begin
      if (h_m == HT - 1) begin
        h_m = 0;
        lw = 1'b1;
        if (v_m == VT - 1) begin
          v_m = 0;
          fw = 1'b1;
        end else begin
          v_m = v_m + 1;
        end
      end else begin
        h_m = h_m + 1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ce_pix = 1'b1;
    tick();
    checks++; if (s_hcount !== 4'd0 || s_vcount !== 3'd0) begin failures++; $display("FAIL reset_pos got=%0d,%0d exp=0,0", s_hcount, s_vcount); end
    checks++; if (s_frame_cnt !== 8'd0) begin failures++; $display("FAIL reset_frame_cnt got=%0d exp=0", s_frame_cnt); end
    checks++; if (s_hblank !== 1'b0 || s_vblank !== 1'b0) begin failures++; $display("FAIL reset_blank got=%b%b exp=00", s_hblank, s_vblank); end
    checks++; if (s_de !== 1'b1) begin failures++; $display("FAIL reset_de got=%b exp=1", s_de); end
    checks++; if (s_hsync !== 1'b1 || s_vsync !== 1'b1) begin failures++; $display("FAIL reset_sync got=%b%b exp=11", s_hsync, s_vsync); end
    checks++; if (s_line_start !== 1'b0 || s_frame_start !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%b%b exp=00", s_line_start, s_frame_start); end
    checks++; if (i_hsync !== 1'b0 || i_vsync !== 1'b0) begin failures++; $display("FAIL reset_inv_sync got=%b%b exp=00", i_hsync, i_vsync); end
    checks++; if (g_hcount !== 10'd0 || g_vcount !== 10'd0 || g_hsync !== 1'b1 || g_de !== 1'b1) begin failures++; $display("FAIL reset_vga got=%0d,%0d hs=%b de=%b exp=0,0 hs=1 de=1", g_hcount, g_vcount, g_hsync, g_de); end
    reset = 1'b0;
  endtask

  task automatic test_full_frame();
    bit lw, fw, hb, vb, hs_on, vs_on;
    int hs_low = 0, vs_low = 0, de_hi = 0, ls_n = 0, fs_n = 0;
    do_reset();
    for (int i = 0; i < HT * VT; i++) begin
      tick();
      model_step(1'b1, lw, fw);
      hb = (h_m >= 8);
      vb = (v_m >= 4);
      hs_on = (h_m >= 10) && (h_m < 13);
      vs_on = (v_m >= 5) && (v_m < 7);
      if (s_hsync === 1'b0) hs_low++;
      if (s_vsync === 1'b0) vs_low++;
      if (s_de === 1'b1) de_hi++;
      if (s_line_start === 1'b1) ls_n++;
      if (s_frame_start === 1'b1) fs_n++;
      checks++; if (s_hcount !== 4'(h_m) || s_vcount !== 3'(v_m)) begin failures++; $display("FAIL frame_pos got=%0d,%0d exp=%0d,%0d", s_hcount, s_vcount, h_m, v_m); end
      checks++; if (s_hblank !== hb || s_vblank !== vb) begin failures++; $display("FAIL frame_blank h=%0d v=%0d got=%b%b exp=%b%b", h_m, v_m, s_hblank, s_vblank, hb, vb); end
      checks++; if (s_de !== (!hb && !vb)) begin failures++; $display("FAIL frame_de h=%0d v=%0d got=%b", h_m, v_m, s_de); end
      checks++; if (s_hsync !== !hs_on || s_vsync !== !vs_on) begin failures++; $display("FAIL frame_sync h=%0d v=%0d got=%b%b exp=%b%b", h_m, v_m, s_hsync, s_vsync, !hs_on, !vs_on); end
      checks++; if (i_hsync !== hs_on || i_vsync !== vs_on) begin failures++; $display("FAIL frame_inv_sync h=%0d v=%0d got=%b%b exp=%b%b", h_m, v_m, i_hsync, i_vsync, hs_on, vs_on); end
      checks++; if (s_line_start !== lw || s_frame_start !== fw) begin failures++; $display("FAIL frame_strobes h=%0d v=%0d got=%b%b exp=%b%b", h_m, v_m, s_line_start, s_frame_start, lw, fw); end
    end
    checks++; if (hs_low != 24 || vs_low != 32) begin failures++; $display("FAIL frame_sync_widths got=%0d,%0d exp=24,32", hs_low, vs_low); end
    checks++; if (de_hi != 32) begin failures++; $display("FAIL frame_de_count got=%0d exp=32", de_hi); end
    checks++; if (ls_n != 8 || fs_n != 1) begin failures++; $display("FAIL frame_strobe_counts got=%0d,%0d exp=8,1", ls_n, fs_n); end
    checks++; if (s_frame_cnt !== 8'd1) begin failures++; $display("FAIL frame_cnt_one got=%0d exp=1", s_frame_cnt); end
  endtask

  task automatic test_vga_line();
    int hs_low = 0, hb_n = 0, ls_n = 0, first_low = -1, ls_at = -1;
    do_reset();
    for (int i = 1; i <= 800; i++) begin
      tick();
      if (g_hsync === 1'b0) begin
        hs_low++;
        if (first_low < 0) first_low = int'(g_hcount);
      end
      if (g_hblank === 1'b1) hb_n++;
      if (g_line_start === 1'b1) begin ls_n++; ls_at = i; end
    end
    checks++; if (hs_low != 96) begin failures++; $display("FAIL vga_hsync_width got=%0d exp=96", hs_low); end
    checks++; if (first_low != 656) begin failures++; $display("FAIL vga_hsync_start got=%0d exp=656", first_low); end
    checks++; if (hb_n != 160) begin failures++; $display("FAIL vga_hblank_width got=%0d exp=160", hb_n); end
    checks++; if (ls_n != 1 || ls_at != 800) begin failures++; $display("FAIL vga_line_period got=%0d@%0d exp=1@800", ls_n, ls_at); end
    checks++; if (g_hcount !== 10'd0 || g_vcount !== 10'd1 || g_vsync !== 1'b1) begin failures++; $display("FAIL vga_line_end got=%0d,%0d vs=%b exp=0,1 vs=1", g_hcount, g_vcount, g_vsync); end
  endtask

  task automatic test_ce_toggle();
    bit lw, fw, ce;
    logic [3:0] ph;
    logic [2:0] pv;
    logic phs, pvs, phb, pvb, pde;
    int last_ls = -1, ls_n = 0, fs_n = 0;
    do_reset();
    for (int i = 0; i < 2 * HT * VT; i++) begin
      ce = (i % 2 == 0);
      ce_pix = ce;
      ph = s_hcount; pv = s_vcount; phs = s_hsync; pvs = s_vsync;
      phb = s_hblank; pvb = s_vblank; pde = s_de;
      tick();
      model_step(ce, lw, fw);
      if (s_frame_start === 1'b1) fs_n++;
      if (s_line_start === 1'b1) begin
        ls_n++;
        if (last_ls >= 0) begin
          checks++; if (i - last_ls != 2 * HT) begin failures++; $display("FAIL ce_line_period got=%0d exp=%0d", i - last_ls, 2 * HT); end
        end
        last_ls = i;
      end
      if (!ce) begin
        checks++; if (s_hcount !== ph || s_vcount !== pv) begin failures++; $display("FAIL ce_hold_pos got=%0d,%0d exp=%0d,%0d", s_hcount, s_vcount, ph, pv); end
        checks++; if (s_hsync !== phs || s_vsync !== pvs || s_hblank !== phb || s_vblank !== pvb || s_de !== pde) begin failures++; $display("FAIL ce_hold_flags i=%0d", i); end
        checks++; if (s_line_start !== 1'b0 || s_frame_start !== 1'b0) begin failures++; $display("FAIL ce_hold_strobes got=%b%b exp=00", s_line_start, s_frame_start); end
      end else begin
        checks++; if (s_hcount !== 4'(h_m) || s_vcount !== 3'(v_m) || s_line_start !== lw) begin failures++; $display("FAIL ce_step got=%0d,%0d ls=%b exp=%0d,%0d ls=%b", s_hcount, s_vcount, s_line_start, h_m, v_m, lw); end
      end
    end
    checks++; if (ls_n != VT || fs_n != 1) begin failures++; $display("FAIL ce_strobe_counts got=%0d,%0d exp=%0d,1", ls_n, fs_n, VT); end
    ce_pix = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    repeat (5 * HT + 9) tick();
    checks++; if (s_hcount !== 4'd9 || s_vcount !== 3'd5 || s_de !== 1'b0 || s_vsync !== 1'b0) begin failures++; $display("FAIL mid_pre got=%0d,%0d de=%b vs=%b exp=9,5 de=0 vs=0", s_hcount, s_vcount, s_de, s_vsync); end
    reset = 1'b1;
    tick();
    checks++; if (s_hcount !== 4'd0 || s_vcount !== 3'd0) begin failures++; $display("FAIL mid_pos got=%0d,%0d exp=0,0", s_hcount, s_vcount); end
    checks++; if (s_de !== 1'b1 || s_hblank !== 1'b0 || s_vblank !== 1'b0) begin failures++; $display("FAIL mid_flags de=%b hb=%b vb=%b exp=1,0,0", s_de, s_hblank, s_vblank); end
    checks++; if (s_hsync !== 1'b1 || s_vsync !== 1'b1) begin failures++; $display("FAIL mid_sync got=%b%b exp=11", s_hsync, s_vsync); end
    checks++; if (s_line_start !== 1'b0 || s_frame_start !== 1'b0) begin failures++; $display("FAIL mid_strobes got=%b%b exp=00", s_line_start, s_frame_start); end
    reset = 1'b0;
    while (n < 40) begin
      tick();
      n++;
      if (s_line_start === 1'b1) break;
    end
    checks++; if (n != HT) begin failures++; $display("FAIL mid_first_line got=%0d exp=%0d", n, HT); end
  endtask

  task automatic test_frame_cnt();
    do_reset();
    for (int f = 1; f <= 257; f++) begin
      repeat (HT * VT) tick();
      checks++; if (s_frame_cnt !== 8'(f % 256) || s_frame_start !== 1'b1) begin failures++; $display("FAIL frame_cnt f=%0d got=%0d fs=%b exp=%0d fs=1", f, s_frame_cnt, s_frame_start, f % 256); end
    end
    checks++; if (i_frame_cnt !== 8'd1) begin failures++; $display("FAIL frame_cnt_inv got=%0d exp=1", i_frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_vga_line();
    test_ce_toggle();
    test_reset_mid();
    test_frame_cnt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
